cart_loader: RTL and testbench

CART_LOADER -- requirements
Module: cart_loader

---
 rtl/sms_pkg.sv | 17 +
 rtl/loader_fifo.sv | 34 +++
 rtl/cart_loader.sv | 90 +++++++++
 tb/tb_cart_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sms_pkg.sv
// sms_pkg: shared types and constants for the cartridge loader
package sms_pkg;
  localparam int BANK_BITS = 14;
  localparam int ADDR_W = 22;
  localparam int FIFO_W = ADDR_W + 8;
  typedef enum logic [1:0] {IDLE, LOAD, PAD, DONE} state_t;
  // Bank mask from the byte count: ceil(count/16 KB) banks, rounded up to 2^k-1.
  function automatic logic [7:0] calc_mask(input logic [22:0] e);
    logic [8:0] m;
    m = e[22:14] + {8'd0, |e[13:0]} - 9'd1;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    return e == '0 ? 8'h00 : m[8] ? 8'hFF : m[7:0];
  endfunction
endpackage

// File: rtl/loader_fifo.sv
// loader_fifo: two-entry buffer between the HPS byte strobe and the SDRAM handshake
module loader_fifo import sms_pkg::*; (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [FIFO_W-1:0] din,
  output logic [FIFO_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  logic [FIFO_W-1:0] mem [2];
  logic wp, rp;
  logic [1:0] cnt;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = cnt == 2'd2;
  assign empty = cnt == 2'd0;
  assign dout = mem[rp];
  // Pointers and occupancy; a flush drops entries but leaves stale data in place.
  always_ff @(posedge clk_sys)
    if (reset || flush) begin
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (do_push) mem[wp] <= din;
      wp <= wp ^ do_push;
      rp <= rp ^ do_pop;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
endmodule

// File: rtl/cart_loader.sv
// cart_loader: streams a ROM download into SDRAM, pads to a 16 KB bank and derives the bank mask
module cart_loader import sms_pkg::*; #(
  parameter logic [7:0] PAD_BYTE = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [7:0]        cart_mask,
  output logic              busy,
  output logic              loaded,
  output logic              overflow
);
  state_t state, state_d;
  logic dl_q, rise, addr_ok, wr_ok, push, pop, full, empty, ack;
  logic [FIFO_W-1:0] head;
  logic [22:0] byte_end, wr_end;
  logic [ADDR_W-1:0] pad_ptr, pad_next;
  assign rise = ioctl_download && !dl_q;
  assign addr_ok = ioctl_addr[24:22] == 3'd0;
  assign wr_ok = state == LOAD && !rise && ioctl_wr;
  assign push = wr_ok && addr_ok && !full;
  assign ack = mem_req && mem_ack;
  assign pop = state == LOAD && ack;
  assign wr_end = {1'b0, ioctl_addr[ADDR_W-1:0]} + 23'd1;
  assign pad_next = pad_ptr + 22'd1;

  loader_fifo u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .flush   (rise),
    .push    (push),
    .pop     (pop),
    .din     ({ioctl_addr[ADDR_W-1:0], ioctl_dout}),
    .dout    (head),
    .full    (full),
    .empty   (empty)
  );

  // State register; reset abandons any outstanding request immediately.
  always_ff @(posedge clk_sys)
    if (reset) state <= IDLE;
    else state <= state_d;

  // A new download always restarts; loading ends once the last byte has drained.
  always_comb
    state_d = rise ? LOAD
      : state == LOAD && !ioctl_download && empty && !mem_req ? (byte_end[BANK_BITS-1:0] == '0 ? DONE : PAD)
      : state == PAD && ack && pad_next[BANK_BITS-1:0] == '0 ? DONE
      : state;

  // Request side follows the FIFO head while loading and the fill pointer while padding.
  always_comb begin
    mem_req = state == PAD || (state == LOAD && !empty);
    mem_addr = state == PAD ? pad_ptr : mem_req ? head[FIFO_W-1:8] : '0;
    mem_din = state == PAD ? PAD_BYTE : mem_req ? head[7:0] : 8'h00;
    ioctl_wait = !empty;
    busy = state == LOAD || state == PAD;
    loaded = state == DONE;
  end

  // Byte count, fill pointer, error flag and bank mask.
  always_ff @(posedge clk_sys)
    if (reset) begin
      dl_q <= 1'b0;
      byte_end <= '0;
      pad_ptr <= '0;
      overflow <= 1'b0;
      cart_mask <= 8'h00;
    end else begin
      dl_q <= ioctl_download;
      if (rise) begin
        byte_end <= '0;
        overflow <= 1'b0;
      end else begin
        if (push && wr_end > byte_end) byte_end <= wr_end;
        if (wr_ok && (!addr_ok || full)) overflow <= 1'b1;
      end
      pad_ptr <= state_d == PAD && state != PAD ? byte_end[ADDR_W-1:0]
        : state == PAD && ack ? pad_next : pad_ptr;
      if (state_d == DONE && state != DONE) cart_mask <= calc_mask(byte_end);
    end
endmodule

// File: tb/tb_cart_loader.sv
// tb_cart_loader: randomized directed checks of cart_loader against a byte-map reference model
module tb_cart_loader;
  localparam logic [7:0] PAD = 8'hFF;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [21:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [7:0]  cart_mask;
  logic        busy, loaded, overflow;

  cart_loader #(.PAD_BYTE(PAD)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_req        (mem_req),
    .mem_ack        (mem_ack),
    .cart_mask      (cart_mask),
    .busy           (busy),
    .loaded         (loaded),
    .overflow       (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {int a; logic [7:0] d;} wr_t;
  wr_t wq[$];
  int ack_dly = 0;
  int cnt = 0;
  int unstable = 0;
  logic pend = 1'b0;
  logic [21:0] sa = '0;
  logic [7:0] sd = '0;

  logic [7:0] exp_mem [int];
  int exp_end, base, base_u;
  int checks = 0;
  int errors = 0;

  // SDRAM model: accepts after ack_dly stalled cycles, logs writes, watches request stability.
  always @(negedge clk_sys)
    if (reset || !mem_req) begin
      mem_ack <= 1'b0;
      pend <= 1'b0;
      cnt <= 0;
    end else begin
      if (pend && (mem_addr !== sa || mem_din !== sd)) unstable <= unstable + 1;
      sa <= mem_addr;
      sd <= mem_din;
      if (cnt >= ack_dly) begin
        mem_ack <= 1'b1;
        wq.push_back('{int'(mem_addr), mem_din});
        cnt <= 0;
        pend <= 1'b0;
      end else begin
        mem_ack <= 1'b0;
        cnt <= cnt + 1;
        pend <= 1'b1;
      end
    end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic int exp_mask_of(input int e);
    int banks, m;
    if (e == 0) return 0;
    banks = (e + 16383) / 16384;
    m = 0;
    while (m < banks - 1) m = m * 2 + 1;
    return m > 255 ? 255 : m;
  endfunction

  task automatic model(input int a, input logic [7:0] d);
    exp_mem[a] = d;
    if (a + 1 > exp_end) exp_end = a + 1;
  endtask

  task automatic start_dl();
    base = wq.size();
    base_u = unstable;
    exp_mem.delete();
    exp_end = 0;
    ioctl_download = 1'b1;
    step();
  endtask

  task automatic strobe(input int a, input logic [7:0] d);
    ioctl_addr = a[24:0];
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    step();
    ioctl_wr = 1'b0;
  endtask

  task automatic send(input int a, input logic [7:0] d);
    int n = 0;
    while (ioctl_wait === 1'b1 && n < 1000) begin
      step();
      n++;
    end
    if (n == 1000) chk("wait_timeout", {31'd0, ioctl_wait}, 32'd0);
    strobe(a, d);
    if (a < 32'h400000) model(a, d);
  endtask

  task automatic finish_dl(input string tag, input logic ovf);
    int mism;
    logic [7:0] obs [int];
    ioctl_download = 1'b0;
    for (int a = exp_end; a % 16384 != 0; a++) exp_mem[a] = PAD;
    for (int i = 0; i < 40000 && loaded !== 1'b1; i++) step();
    for (int i = base; i < wq.size(); i++) obs[wq[i].a] = wq[i].d;
    mism = obs.num() != exp_mem.num() ? 1 : 0;
    foreach (exp_mem[k]) if (!obs.exists(k) || obs[k] !== exp_mem[k]) mism++;
    chk({tag, "_loaded"}, {31'd0, loaded}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_mask"}, {24'd0, cart_mask}, exp_mask_of(exp_end));
    chk({tag, "_writes"}, wq.size() - base, exp_mem.num());
    chk({tag, "_mem"}, mism, 32'd0);
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, ovf});
    chk({tag, "_stable"}, unstable - base_u, 32'd0);
  endtask

  initial begin
    int a;
    logic [7:0] d0;
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    repeat (3) step();
    chk("rst_wait", {31'd0, ioctl_wait}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", {10'd0, mem_addr}, 32'd0);
    chk("rst_din", {24'd0, mem_din}, 32'd0);
    chk("rst_mask", {24'd0, cart_mask}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_loaded", {31'd0, loaded}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    step();

    // Out-of-range address only: nothing written, overflow sticks, empty cart.
    start_dl();
    send(32'h400000, 8'hA5);
    chk("bad_ovf", {31'd0, overflow}, 32'd1);
    chk("bad_req", {31'd0, mem_req}, 32'd0);
    chk("bad_wait", {31'd0, ioctl_wait}, 32'd0);
    finish_dl("bad", 1'b1);

    // Full 32 KB image streamed back to back with immediate acceptance.
    ack_dly = 0;
    start_dl();
    for (int i = 0; i < 32768; i++) begin
      d0 = 8'($urandom);
      strobe(i, d0);
      model(i, d0);
    end
    finish_dl("k32", 1'b0);

    // Slow SDRAM: latency, backpressure, stability, full-FIFO drop, then a sparse 48 KB image.
    ack_dly = 10;
    start_dl();
    d0 = 8'($urandom);
    strobe(32'h100, d0);
    model(32'h100, d0);
    chk("lat_req", {31'd0, mem_req}, 32'd1);
    chk("lat_addr", {10'd0, mem_addr}, 32'h100);
    chk("lat_din", {24'd0, mem_din}, {24'd0, d0});
    chk("lat_wait", {31'd0, ioctl_wait}, 32'd1);
    a = $urandom;
    strobe(32'h101, 8'(a));
    model(32'h101, 8'(a));
    strobe(32'h102, 8'h5A);
    chk("full_ovf", {31'd0, overflow}, 32'd1);
    repeat (6) step();
    chk("stall_wait", {31'd0, ioctl_wait}, 32'd1);
    chk("stall_addr", {10'd0, mem_addr}, 32'h100);
    chk("stall_din", {24'd0, mem_din}, {24'd0, d0});
    a = 32'h102;
    for (int i = 0; i < 5; i++) begin
      a = a + int'($urandom_range(1, 9000));
      send(a, 8'($urandom));
    end
    send(49151, 8'($urandom));
    finish_dl("k48", 1'b1);

    // Reset while padding drops the request at once.
    ack_dly = 0;
    start_dl();
    send(32'h10, 8'($urandom));
    send(99, 8'($urandom));
    ioctl_download = 1'b0;
    repeat (5) step();
    chk("pad_req", {31'd0, mem_req}, 32'd1);
    chk("pad_busy", {31'd0, busy}, 32'd1);
    chk("pad_din", {24'd0, mem_din}, {24'd0, PAD});
    chk("pad_range", {31'd0, mem_addr >= 22'd100 && mem_addr < 22'd16384}, 32'd1);
    reset = 1'b1;
    step();
    chk("rpad_req", {31'd0, mem_req}, 32'd0);
    chk("rpad_loaded", {31'd0, loaded}, 32'd0);
    chk("rpad_busy", {31'd0, busy}, 32'd0);
    chk("rpad_mask", {24'd0, cart_mask}, 32'd0);
    chk("rpad_wait", {31'd0, ioctl_wait}, 32'd0);
    chk("rpad_addr", {10'd0, mem_addr}, 32'd0);
    reset = 1'b0;
    step();

    // 16896-byte image: padded with fill bytes up to the 32 KB boundary.
    start_dl();
    a = 0;
    for (int i = 0; i < 6; i++) begin
      a = a + int'($urandom_range(1, 2500));
      send(a, 8'($urandom));
    end
    send(16895, 8'($urandom));
    finish_dl("k16", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
